// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes and the slave-bus FSM state encoding.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_WRESP  = 2'd2;
    localparam state_t ST_RRESP  = 2'd3;

endpackage

// File: rtl/axi4_lite_if.sv
// Project AXI4-Lite interface; 's' is the slave view, 'm' the master view.
interface axi4_lite_if #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic ACLK,
    input logic ARESETn
);
    localparam int SW = DW / 8;

    logic [AW-1:0] AWADDR;
    logic [2:0]    AWPROT;
    logic          AWVALID;
    logic          AWREADY;
    logic [DW-1:0] WDATA;
    logic [SW-1:0] WSTRB;
    logic          WVALID;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [AW-1:0] ARADDR;
    logic [2:0]    ARPROT;
    logic          ARVALID;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY;

    modport s (
        input  AWADDR, AWPROT, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID,    output WREADY,
        output BRESP, BVALID,           input  BREADY,
        input  ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID,    input  RREADY
    );

    modport m (
        input  ACLK, ARESETn,
        output AWADDR, AWPROT, AWVALID, input  AWREADY,
        output WDATA, WSTRB, WVALID,    input  WREADY,
        input  BRESP, BVALID,           output BREADY,
        output ARADDR, ARPROT, ARVALID, input  ARREADY,
        input  RDATA, RRESP, RVALID,    output RREADY
    );

endinterface

// File: rtl/axi4_lite_slave_bus.sv
// AXI4-Lite slave to single-outstanding strobe/ack register bus, round-robin R/W.
// Optional access timeout enabled by defining AXI4_LITE_SLAVE_BUS_TIMEOUT_EN.
module axi4_lite_slave_bus
    import axi4_lite_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SW      = DW / 8,
    parameter int TIMEOUT = 255
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    axi4_lite_if.s        axi,
    output logic          bus_wen,
    output logic          bus_ren,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic [SW-1:0] bus_sel,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack,
    input  logic          bus_err
);

    state_t state;
    logic   last_rd;
    logic   is_wr;
    logic   wr_pend, rd_pend, pick_wr, pick_rd;
    logic   done, fail;
    logic   unused_prot;

    assign unused_prot = ^{axi.AWPROT, axi.ARPROT};

    // A write needs both AW and W present; ties go to the type not served last.
    assign wr_pend = axi.AWVALID & axi.WVALID;
    assign rd_pend = axi.ARVALID;
    assign pick_wr = wr_pend & (~rd_pend | last_rd);
    assign pick_rd = rd_pend & ~pick_wr;

`ifdef AXI4_LITE_SLAVE_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tcnt;
    logic          expired;

    assign expired = (tcnt == CW'(TIMEOUT - 1));
    assign done    = bus_ack | bus_err | expired;
    assign fail    = bus_err | (expired & ~bus_ack);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            tcnt <= '0;
        else if (state != ST_ACCESS)
            tcnt <= '0;
        else if (!(bus_ack | bus_err))
            tcnt <= tcnt + 1'b1;
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign done = bus_ack | bus_err;
    assign fail = bus_err;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state       <= ST_IDLE;
            last_rd     <= 1'b1;
            is_wr       <= 1'b0;
            axi.AWREADY <= 1'b0;
            axi.WREADY  <= 1'b0;
            axi.ARREADY <= 1'b0;
            axi.BVALID  <= 1'b0;
            axi.BRESP   <= OKAY;
            axi.RVALID  <= 1'b0;
            axi.RRESP   <= OKAY;
            axi.RDATA   <= '0;
            bus_wen     <= 1'b0;
            bus_ren     <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_sel     <= '0;
        end else begin
            // READY and strobes are one-cycle pulses in the first ACCESS cycle.
            axi.AWREADY <= 1'b0;
            axi.WREADY  <= 1'b0;
            axi.ARREADY <= 1'b0;
            bus_wen     <= 1'b0;
            bus_ren     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_wr) begin
                        bus_addr    <= axi.AWADDR;
                        bus_wdata   <= axi.WDATA;
                        bus_sel     <= axi.WSTRB;
                        is_wr       <= 1'b1;
                        last_rd     <= 1'b0;
                        axi.AWREADY <= 1'b1;
                        axi.WREADY  <= 1'b1;
                        bus_wen     <= 1'b1;
                        state       <= ST_ACCESS;
                    end else if (pick_rd) begin
                        bus_addr    <= axi.ARADDR;
                        bus_sel     <= '1;
                        is_wr       <= 1'b0;
                        last_rd     <= 1'b1;
                        axi.ARREADY <= 1'b1;
                        bus_ren     <= 1'b1;
                        state       <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (done) begin
                        if (is_wr) begin
                            axi.BVALID <= 1'b1;
                            axi.BRESP  <= fail ? SLVERR : OKAY;
                            state      <= ST_WRESP;
                        end else begin
                            axi.RVALID <= 1'b1;
                            axi.RRESP  <= fail ? SLVERR : OKAY;
                            axi.RDATA  <= fail ? '0 : bus_rdata;
                            state      <= ST_RRESP;
                        end
                    end
                end
                ST_WRESP: begin
                    if (axi.BREADY) begin
                        axi.BVALID <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                ST_RRESP: begin
                    if (axi.RREADY) begin
                        axi.RVALID <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_bus.sv
// Bench for axi4_lite_slave_bus: vector table, corner sequences, random scoreboard.
module tb_axi4_lite_slave_bus;

    logic        ACLK;
    logic        ARESETn;
    logic        bus_wen, bus_ren;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_sel;
    logic        bus_ack, bus_err;

    axi4_lite_if #(.AW(32), .DW(32)) axi (.ACLK(ACLK), .ARESETn(ARESETn));

    axi4_lite_slave_bus #(.AW(32), .DW(32), .SW(4), .TIMEOUT(8)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .axi(axi),
        .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_sel(bus_sel), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .bus_err(bus_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    // Peripheral model behind the bus and its responder state
    logic [31:0] mem   [16];
    logic [31:0] model [16];
    bit          auto_resp = 1'b0;
    int          cur_dly   = 0;
    bit          cur_err   = 1'b0;
    bit          pend      = 1'b0;
    bit          pend_wr   = 1'b0;
    int          dcnt      = 0;
    int          wen_cnt   = 0;
    int          ren_cnt   = 0;
    logic [31:0] s_addr, s_data;
    logic [3:0]  s_sel;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          dly;
        bit          err;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
        bus_ack = 1'b0;
        bus_err = 1'b0;
        if (bus_wen) wen_cnt++;
        if (bus_ren) ren_cnt++;
        if (bus_wen || bus_ren) begin
            s_addr = bus_addr;
            s_data = bus_wdata;
            s_sel  = bus_sel;
        end
        if (auto_resp) begin
            if (bus_wen || bus_ren) begin
                pend    = 1'b1;
                pend_wr = bus_wen;
                dcnt    = cur_dly;
            end
            if (pend) begin
                if (dcnt == 0) begin
                    pend      = 1'b0;
                    bus_rdata = mem[s_addr[5:2]];
                    if (cur_err) bus_err = 1'b1;
                    else begin
                        bus_ack = 1'b1;
                        if (pend_wr) mem[s_addr[5:2]] = merge(mem[s_addr[5:2]], s_data, s_sel);
                    end
                end else dcnt--;
            end
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int rdy_dly, output logic [1:0] resp);
        int n;
        int w0;
        w0 = wen_cnt;
        axi.AWADDR = a; axi.AWPROT = 3'($urandom); axi.WDATA = d; axi.WSTRB = s;
        axi.AWVALID = 1'b1; axi.WVALID = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!axi.AWREADY && n < 50);
        chk("wr_awready", 64'(axi.AWREADY), 64'(1));
        tick();
        axi.AWVALID = 1'b0; axi.WVALID = 1'b0;
        n = 0;
        while (!axi.BVALID && n < 50) begin tick(); n++; end
        chk("wr_bvalid", 64'(axi.BVALID), 64'(1));
        repeat (rdy_dly) tick();
        resp = axi.BRESP;
        axi.BREADY = 1'b1; tick(); axi.BREADY = 1'b0;
        chk("wr_bvalid_drop", 64'(axi.BVALID), 64'(0));
        chk("wr_strobes", 64'(wen_cnt - w0), 64'(1));
        chk("wr_bus_addr", 64'(s_addr), 64'(a));
        chk("wr_bus_data", 64'(s_data), 64'(d));
        chk("wr_bus_sel", 64'(s_sel), 64'(s));
    endtask

    task automatic do_read(input logic [31:0] a, input int rdy_dly,
                           output logic [1:0] resp, output logic [31:0] data);
        int n;
        int r0;
        r0 = ren_cnt;
        axi.ARADDR = a; axi.ARPROT = 3'($urandom); axi.ARVALID = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!axi.ARREADY && n < 50);
        chk("rd_arready", 64'(axi.ARREADY), 64'(1));
        tick();
        axi.ARVALID = 1'b0;
        n = 0;
        while (!axi.RVALID && n < 50) begin tick(); n++; end
        chk("rd_rvalid", 64'(axi.RVALID), 64'(1));
        repeat (rdy_dly) tick();
        resp = axi.RRESP;
        data = axi.RDATA;
        axi.RREADY = 1'b1; tick(); axi.RREADY = 1'b0;
        chk("rd_rvalid_drop", 64'(axi.RVALID), 64'(0));
        chk("rd_strobes", 64'(ren_cnt - r0), 64'(1));
        chk("rd_bus_addr", 64'(s_addr), 64'(a));
        chk("rd_bus_sel", 64'(s_sel), 64'(4'hF));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        int          c, n, viol, r0, w0;
        int          seq[$];
        bit          drop_w, drop_r;

        tbl[0] = '{0, 32'h40, 32'h0,        4'h0, 0, 0, 2'b00, 32'h0000BEEF};
        tbl[1] = '{1, 32'h44, 32'h12345678, 4'hF, 2, 0, 2'b00, 32'h0};
        tbl[2] = '{0, 32'h44, 32'h0,        4'h0, 1, 0, 2'b00, 32'h12345678};
        tbl[3] = '{1, 32'h40, 32'hAABBCCDD, 4'hC, 1, 0, 2'b00, 32'h0};
        tbl[4] = '{0, 32'h40, 32'h0,        4'h0, 0, 0, 2'b00, 32'hAABBBEEF};
        tbl[5] = '{0, 32'h44, 32'h0,        4'h0, 0, 1, 2'b10, 32'h0};
        tbl[6] = '{1, 32'h44, 32'hFFFFFFFF, 4'hF, 2, 1, 2'b10, 32'h0};
        tbl[7] = '{0, 32'h44, 32'h0,        4'h0, 3, 0, 2'b00, 32'h12345678};
        tbl[8] = '{1, 32'h4C, 32'hCAFEF00D, 4'h5, 0, 0, 2'b00, 32'h0};
        tbl[9] = '{0, 32'h4C, 32'h0,        4'h0, 0, 0, 2'b00, 32'h00FE000D};

        for (int i = 0; i < 16; i++) mem[i] = '0;
        ARESETn = 1'b0;
        axi.AWADDR = '0; axi.AWPROT = '0; axi.AWVALID = 1'b0;
        axi.WDATA = '0; axi.WSTRB = '0; axi.WVALID = 1'b0; axi.BREADY = 1'b0;
        axi.ARADDR = '0; axi.ARPROT = '0; axi.ARVALID = 1'b0; axi.RREADY = 1'b0;
        bus_rdata = '0; bus_ack = 1'b0; bus_err = 1'b0;
        repeat (3) tick();
        chk("reset_ctrl", 64'({axi.AWREADY, axi.WREADY, axi.ARREADY, axi.BVALID,
                                axi.RVALID, bus_wen, bus_ren}), 64'(0));
        chk("reset_resp", 64'({axi.BRESP, axi.RRESP}), 64'(0));
        chk("reset_data", 64'({axi.RDATA, bus_wdata}), 64'(0));
        chk("reset_addr_sel", 64'({bus_addr, bus_sel}), 64'(0));
        ARESETn = 1'b1;
        tick();

        // Simultaneous write and read after reset: write first, then read, twice
        auto_resp = 1'b1; cur_dly = 0; cur_err = 1'b0;
        axi.BREADY = 1'b1; axi.RREADY = 1'b1;
        for (int round = 0; round < 2; round++) begin
            seq.delete();
            axi.AWADDR = 32'h08; axi.WDATA = 32'h11110000 + round; axi.WSTRB = 4'hF;
            axi.ARADDR = 32'h0C;
            axi.AWVALID = 1'b1; axi.WVALID = 1'b1; axi.ARVALID = 1'b1;
            drop_w = 1'b0; drop_r = 1'b0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (drop_w) begin axi.AWVALID = 1'b0; axi.WVALID = 1'b0; drop_w = 1'b0; end
                if (drop_r) begin axi.ARVALID = 1'b0; drop_r = 1'b0; end
                if (axi.AWREADY) drop_w = 1'b1;
                if (axi.ARREADY) drop_r = 1'b1;
                if (bus_wen) seq.push_back(1);
                if (bus_ren) seq.push_back(0);
            end
            chk("arb_count", 64'(seq.size()), 64'(2));
            if (seq.size() == 2) begin
                chk("arb_first_is_write", 64'(seq[0]), 64'(1));
                chk("arb_second_is_read", 64'(seq[1]), 64'(0));
            end
        end
        axi.BREADY = 1'b0; axi.RREADY = 1'b0;

        // Write with ack in the strobe cycle: cycle-exact latency
        axi.BREADY = 1'b1;
        axi.AWADDR = 32'h40; axi.WDATA = 32'hDEADBEEF; axi.WSTRB = 4'b0011;
        axi.AWVALID = 1'b1; axi.WVALID = 1'b1;
        tick();
        chk("lat_c1_ready", 64'({axi.AWREADY, axi.WREADY, bus_wen}), 64'(3'b111));
        chk("lat_c1_addr", 64'(bus_addr), 64'(32'h40));
        chk("lat_c1_wdata", 64'(bus_wdata), 64'(32'hDEADBEEF));
        chk("lat_c1_sel", 64'(bus_sel), 64'(4'b0011));
        chk("lat_c1_bvalid", 64'(axi.BVALID), 64'(0));
        tick();
        axi.AWVALID = 1'b0; axi.WVALID = 1'b0;
        chk("lat_c2_bvalid", 64'(axi.BVALID), 64'(1));
        chk("lat_c2_bresp", 64'(axi.BRESP), 64'(2'b00));
        chk("lat_c2_pulses_off", 64'({axi.AWREADY, axi.WREADY, bus_wen}), 64'(0));
        tick();
        chk("lat_c3_bvalid", 64'(axi.BVALID), 64'(0));
        axi.BREADY = 1'b0;

        // Vector table
        for (int i = 0; i < 10; i++) begin
            cur_dly = tbl[i].dly; cur_err = tbl[i].err;
            if (tbl[i].wr) begin
                do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, i % 3, resp);
                chk("tbl_bresp", 64'(resp), 64'(tbl[i].exp_resp));
            end else begin
                do_read(tbl[i].addr, i % 3, resp, rd);
                chk("tbl_rresp", 64'(resp), 64'(tbl[i].exp_resp));
                chk("tbl_rdata", 64'(rd), 64'(tbl[i].exp_rdata));
            end
        end
        cur_err = 1'b0;

        // Read with 5-cycle ack delay and RREADY held low for 3 cycles
        cur_dly = 5; r0 = ren_cnt;
        axi.ARADDR = 32'h44; axi.ARVALID = 1'b1;
        tick(); c = 1;
        chk("rd5_strobe", 64'({axi.ARREADY, bus_ren}), 64'(2'b11));
        tick(); c = 2;
        axi.ARVALID = 1'b0;
        n = 0;
        while (!axi.RVALID && n < 20) begin tick(); c++; n++; end
        chk("rd5_rvalid_cycle", 64'(c), 64'(7));
        for (int k = 0; k < 3; k++) begin
            chk("rd5_hold_rvalid", 64'(axi.RVALID), 64'(1));
            chk("rd5_hold_rdata", 64'(axi.RDATA), 64'(32'h12345678));
            chk("rd5_hold_rresp", 64'(axi.RRESP), 64'(2'b00));
            if (k < 2) tick();
        end
        axi.RREADY = 1'b1; tick(); axi.RREADY = 1'b0;
        chk("rd5_rvalid_drop", 64'(axi.RVALID), 64'(0));
        chk("rd5_one_strobe", 64'(ren_cnt - r0), 64'(1));

        // AW without W is not a pending write
        cur_dly = 0; w0 = wen_cnt; viol = 0;
        axi.AWADDR = 32'h50; axi.WDATA = 32'h01020304; axi.WSTRB = 4'hF;
        axi.AWVALID = 1'b1; axi.WVALID = 1'b0;
        repeat (10) begin
            tick();
            if (axi.AWREADY || axi.WREADY || bus_wen) viol++;
        end
        chk("awonly_quiet", 64'(viol), 64'(0));
        chk("awonly_no_strobe", 64'(wen_cnt - w0), 64'(0));
        axi.WVALID = 1'b1;
        tick();
        chk("awonly_go", 64'({axi.AWREADY, axi.WREADY, bus_wen}), 64'(3'b111));
        tick();
        axi.AWVALID = 1'b0; axi.WVALID = 1'b0;
        chk("awonly_bvalid", 64'(axi.BVALID), 64'(1));
        axi.BREADY = 1'b1; tick(); axi.BREADY = 1'b0;
        chk("awonly_bvalid_drop", 64'(axi.BVALID), 64'(0));

        // Reset while waiting in ACCESS
        auto_resp = 1'b0; pend = 1'b0;
        axi.RREADY = 1'b1; axi.BREADY = 1'b1;
        axi.ARADDR = 32'h58; axi.ARVALID = 1'b1;
        tick();
        chk("rst_strobe", 64'(bus_ren), 64'(1));
        tick();
        axi.ARVALID = 1'b0;
        tick();
        #2 ARESETn = 1'b0;
        #1;
        chk("rst_async_ctrl", 64'({axi.AWREADY, axi.WREADY, axi.ARREADY, axi.BVALID,
                                    axi.RVALID, bus_wen, bus_ren, bus_sel}), 64'(0));
        chk("rst_async_addr", 64'(bus_addr), 64'(0));
        tick();
        ARESETn = 1'b1;
        viol = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 1) bus_ack = 1'b1;
            if (axi.RVALID || axi.BVALID) viol++;
        end
        chk("rst_no_stale_resp", 64'(viol), 64'(0));
        axi.RREADY = 1'b0; axi.BREADY = 1'b0;

        // No ack at all: timeout (if enabled) or indefinite wait
        axi.ARADDR = 32'h5C; axi.ARVALID = 1'b1;
        tick(); c = 1;
        chk("to_strobe", 64'(bus_ren), 64'(1));
        tick(); c = 2;
        axi.ARVALID = 1'b0;
`ifdef AXI4_LITE_SLAVE_BUS_TIMEOUT_EN
        n = 0;
        while (!axi.RVALID && n < 30) begin tick(); c++; n++; end
        chk("to_rvalid_cycle", 64'(c), 64'(9));
        chk("to_rresp", 64'(axi.RRESP), 64'(2'b10));
        chk("to_rdata", 64'(axi.RDATA), 64'(0));
        while (c < 12) begin tick(); c++; end
        bus_rdata = 32'h5555AAAA; bus_ack = 1'b1;
        tick(); c++;
        chk("to_late_ack_rvalid", 64'(axi.RVALID), 64'(1));
        chk("to_late_ack_rresp", 64'(axi.RRESP), 64'(2'b10));
        chk("to_late_ack_rdata", 64'(axi.RDATA), 64'(0));
`else
        viol = 0;
        repeat (20) begin
            tick();
            if (axi.RVALID) viol++;
        end
        chk("noto_waits", 64'(viol), 64'(0));
        bus_rdata = 32'h5555AAAA; bus_ack = 1'b1;
        tick();
        chk("noto_rvalid", 64'(axi.RVALID), 64'(1));
        chk("noto_rresp", 64'(axi.RRESP), 64'(2'b00));
        chk("noto_rdata", 64'(axi.RDATA), 64'(32'h5555AAAA));
`endif
        axi.RREADY = 1'b1; tick(); axi.RREADY = 1'b0;
        chk("to_rvalid_drop", 64'(axi.RVALID), 64'(0));

        // Random single transactions against the register scoreboard
        auto_resp = 1'b1; pend = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = mem[i];
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, d;
            logic [3:0]  s;
            int          idx;
            idx = $urandom_range(0, 15);
            a = 32'h100 | 32'(idx << 2);
            cur_dly = $urandom_range(0, 3);
            cur_err = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                do_write(a, d, s, $urandom_range(0, 2), resp);
                chk("rnd_bresp", 64'(resp), cur_err ? 64'(2'b10) : 64'(2'b00));
                if (!cur_err)
                    for (int b = 0; b < 4; b++)
                        if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
            end else begin
                do_read(a, $urandom_range(0, 2), resp, rd);
                chk("rnd_rresp", 64'(resp), cur_err ? 64'(2'b10) : 64'(2'b00));
                chk("rnd_rdata", 64'(rd), cur_err ? 64'(0) : 64'(model[idx]));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
